// File: rtl/fifo_rx_pkg.sv
// fifo_rx_pkg: shared defaults for the receive-side byte FIFO.
package fifo_rx_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int AF_LEVEL_DEF = 12;

  // Pointer width carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);

endpackage

// File: rtl/fifo_rx_mem.sv
// fifo_rx_mem: DEPTH x DATA_W storage, synchronous write, asynchronous read.
module fifo_rx_mem
  import fifo_rx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store the incoming byte; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_rx.sv
// fifo_rx: byte buffer behind the UART receiver with full/empty/almost-full,
// occupancy and a sticky overrun flag.
// Build option: define FIFO_RX_FWFT_EN for first-word-fall-through read data;
// otherwise data_out is a register loaded on each accepted read.
module fifo_rx
  import fifo_rx_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AF_LEVEL = AF_LEVEL_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_drop;
  logic [DATA_W-1:0] mem_rd;

  // Status decoded straight from the registered pointers.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                       (wr_ptr[AW] != rd_ptr[AW]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = (count >= PTR_W'(AF_LEVEL));

  // A pop on a full FIFO frees the slot the same-cycle write lands in.
  assign rd_acc  = rd_en && !empty;
  assign wr_acc  = wr_en && (!full || rd_acc);
  assign wr_drop = wr_en && full && !rd_acc;

  fifo_rx_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (data_in),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rd)
  );

  // Pointer advance on accepted writes and reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overrun: a dropped byte takes priority over a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overrun <= 1'b0;
    else if (wr_drop) overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

`ifdef FIFO_RX_FWFT_EN
  // Head word shown as soon as it is stored; zero while nothing is held.
  always_comb begin
    data_out = empty ? '0 : mem_rd;
  end
`else
  // Registered read data, updated only when a pop is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      data_out <= '0;
    else if (rd_acc) data_out <= mem_rd;
  end
`endif

endmodule

// File: tb/tb_fifo_rx.sv
// tb_fifo_rx: scoreboard bench for fifo_rx (default 8 x 16, AF_LEVEL 12).
module tb_fifo_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] data_out;
  logic       empty, full, almost_full, overrun;
  logic [4:0] count;
  logic       ovr_clr = 1'b0;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] sb[$];

  fifo_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required < 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write one byte; the scoreboard takes it only when the FIFO has room.
  task automatic do_write(input logic [7:0] v);
    data_in = v;
    wr_en   = 1'b1;
    if (sb.size() < 16) sb.push_back(v);
    tick();
    wr_en = 1'b0;
  endtask

  // Pop one byte, sampling data_out where the current read mode presents it.
  task automatic do_read(output logic [7:0] d);
    rd_en = 1'b1;
`ifdef FIFO_RX_FWFT_EN
    d = data_out;
    tick();
`else
    tick();
    d = data_out;
`endif
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_tests++;
    if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", data_out); end
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    n_tests++;
    if (full !== 1'b0 || almost_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_full_af: got %b%b want 00", full, almost_full);
    end
  endtask

  task automatic test_order();
    logic [7:0] d, e;
    do_write(8'hA5);
    n_tests++;
    if (empty !== 1'b0) begin n_fail++; $display("FAIL order_not_empty: got %b want 0", empty); end
    do_write(8'h3C);
    do_write(8'hFF);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
      do_read(d);
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL order_data[%0d]: got %h want %h", i, d, e); end
    end
    n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL order_empty_after: got %b want 1", empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      do_write(8'(i));
      n_tests++;
      if (count !== 5'(i + 1) || almost_full !== (i + 1 >= 12) || full !== (i + 1 == 16)) begin
        n_fail++;
        $display("FAIL fill_status[%0d]: got cnt=%0d af=%b full=%b want cnt=%0d af=%b full=%b",
                 i, count, almost_full, full, i + 1, (i + 1 >= 12), (i + 1 == 16));
      end
    end
    do_write(8'h55);
    n_tests++;
    if (overrun !== 1'b1 || count !== 5'd16) begin
      n_fail++; $display("FAIL fill_overrun: got ovr=%b cnt=%0d want ovr=1 cnt=16", overrun, count);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_full_rw();
    logic [7:0] d, e;
    e = sb.pop_front();
    sb.push_back(8'h77);
    data_in = 8'h77;
    wr_en   = 1'b1;
    do_read(d);
    wr_en   = 1'b0;
    n_tests++;
    if (d !== e) begin n_fail++; $display("FAIL fullrw_pop: got %h want %h", d, e); end
    n_tests++;
    if (count !== 5'd16 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL fullrw_status: got cnt=%0d ovr=%b want cnt=16 ovr=0", count, overrun);
    end
    for (int i = 0; i < 16; i++) begin
      e = sb.pop_front();
      do_read(d);
      n_tests++;
      if (d !== e) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, d, e); end
    end
    n_tests++;
    if (d !== 8'h77 || empty !== 1'b1) begin
      n_fail++; $display("FAIL drain_last: got %h empty=%b want 77 empty=1", d, empty);
    end
    // Read on empty must leave data_out alone in registered mode.
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_read: got cnt=%0d empty=%b want cnt=0 empty=1", count, empty);
    end
`ifndef FIFO_RX_FWFT_EN
    n_tests++;
    if (data_out !== 8'h77) begin n_fail++; $display("FAIL empty_read_hold: got %h want 77", data_out); end
`endif
  endtask

  task automatic test_wrap();
    logic [7:0] d, e;
    for (int i = 0; i < 40; i++) begin
      do_write(8'(8'h80 + i));
      n_tests++;
      if (count !== 5'd1) begin n_fail++; $display("FAIL wrap_cnt_w[%0d]: got %0d want 1", i, count); end
      e = sb.pop_front();
      do_read(d);
      n_tests++;
      if (d !== e || count !== 5'd0) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h cnt=%0d want %h cnt=0", i, d, count, e);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) do_write(8'(8'hC0 + i));
    n_tests++;
    if (count !== 5'd5) begin n_fail++; $display("FAIL ar_count_pre: got %0d want 5", count); end
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_tests++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0 ||
        overrun !== 1'b0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL ar_immediate: got cnt=%0d e=%b f=%b af=%b ovr=%b d=%h want 0 1 0 0 0 00",
               count, empty, full, almost_full, overrun, data_out);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) do_write(8'(i));
    // Overrun set and clear in the same cycle: set wins.
    data_in = 8'h99;
    wr_en   = 1'b1;
    ovr_clr = 1'b1;
    tick();
    wr_en   = 1'b0;
    ovr_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr_after: got %b want 0", overrun); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill();
    test_full_rw();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rx.md
# fifo_rx

Receive-side byte buffer placed directly downstream of the UART `receiver`.
- Captures each completed frame byte on the receiver's one-cycle end-of-frame strobe and holds it until the host/PC side pops it.
- Provides full, empty, almost-full and occupancy status, plus a sticky overrun flag for bytes lost while full.
- Mirrors `fifo_tx` on the transmit path.

## Interface
Parameters:
- `DATA_W`, 8: frame data width in bits.
- `DEPTH`, 16: number of entries; must be a power of two, at least 2.
- `AF_LEVEL`, 12: `almost_full` asserts when `count >= AF_LEVEL`; legal range 1..DEPTH.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  receiver-domain clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `data_in`  in  DATA_W  received byte from `receiver`.
- `wr_en`  in  1  one-cycle strobe from the receiver's `dma_rxend`; `data_in` is valid in the same cycle.
- `rd_en`  in  1  host pop request.
- `data_out`  out  DATA_W  head/read data.
- `empty`  out  1  no stored entries.
- `full`  out  1  `count == DEPTH`.
- `almost_full`  out  1  `count >= AF_LEVEL`.
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overrun`  out  1  sticky; set when a write is dropped.
- `ovr_clr`  in  1  clears `overrun`.

## Operation
Pointers:
- Write and read pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit.
- `empty` when the pointers are equal; `full` when the low bits are equal and the MSBs differ.
- `count` is `wr_ptr - rd_ptr`, computed modulo 2^(log2(DEPTH)+1).
- Pointers increment by one and roll naturally from DEPTH-1 to 0 in the address bits.

Writes and reads:
- Write is accepted when `wr_en && (!full || rd_acc)`; it stores `data_in` at `wr_ptr` and increments `wr_ptr`.
- Read is accepted (`rd_acc`) when `rd_en && !empty`; it increments `rd_ptr`.
- Read on empty is ignored: no pointer change, `data_out` unchanged.

Simultaneous events:
- Full with read and write in the same cycle: both are accepted, count stays DEPTH, no overrun.
- Empty with read and write in the same cycle: only the write happens; there is no bypass.

Overrun flag:
- `wr_en` while full with no accepted read: the byte is discarded and `overrun` is set.
- `ovr_clr` clears `overrun` on the next edge.
- If a set event and `ovr_clr` occur in the same cycle, set wins.

Reset:
- All pointers are 0, so `empty`=1, `full`=0, `almost_full`=0, `count`=0.
- `overrun`=0 and `data_out`=0.
- Memory contents are not reset.
- Asserting reset mid-operation discards all stored data immediately (asynchronous); the first edge after release behaves as a fresh FIFO.

## Timing
- Status outputs (`empty`, `full`, `almost_full`, `count`) derive from registered pointers and reflect operations one edge after they occur.
- A write at edge N makes `empty` deassert after edge N. The entry is poppable from the cycle following edge N.
- Back-to-back `wr_en` and `rd_en` every cycle are supported at full throughput.
- `receiver` strobes are at most one per frame, so no backpressure path exists; loss is reported only through `overrun`.

## Configuration
Macro `FIFO_RX_FWFT_EN` selects first-word-fall-through mode.

When defined (FWFT):
- `data_out` combinationally presents `mem[rd_ptr]` whenever `!empty`, and is 0 when empty.
- `rd_en` acknowledges and pops the shown word.
- Write-to-visible latency is 1 edge.

When undefined (standard):
- `data_out` is a register, loaded with `mem[rd_ptr]` on the edge where a read is accepted.
- Data is valid the cycle after `rd_en`, and holds its value until the next accepted read.

## Structure
- Package `fifo_rx_pkg`: default `DATA_W`, `DEPTH` and `AF_LEVEL` constants, plus the pointer-width constant derived from `DEPTH`.
- Sub-module `fifo_rx_mem`: DEPTH x DATA_W register array with synchronous write and asynchronous read. All pointer, flag and output logic stays in `fifo_rx`.

## Test plan
- Reset, then idle: `empty`=1, `count`=0, `data_out`=0, `overrun`=0.
- Write 0xA5, 0x3C, 0xFF, then read three times: bytes return in order 0xA5, 0x3C, 0xFF (FWFT: same cycle as `rd_en`; standard: one cycle later); `empty`=1 afterwards.
- Write 16 bytes 0x00..0x0F: `almost_full` rises when `count` reaches 12 and `full` when it reaches 16. A 17th `wr_en` with 0x55 sets `overrun`, and 0x55 is never read back.
- When full, strobe `wr_en`(0x77) and `rd_en` in the same cycle: pops 0x00, `count` stays 16, `overrun` unchanged, and 0x77 is the last byte read out.
- Wrap-around: 40 interleaved write/read pairs with an incrementing pattern: every byte matches, `count` never exceeds 1.
- Assert `rst_n` low mid-stream with `count`=5: all flags go to reset values immediately (asynchronously); `ovr_clr` and overrun set in the same cycle leave `overrun`=1.
